// File: rtl/gpr_mport_pkg.sv
// Shared types for the multi-port GPR file.
// Holds the clear/run sequencer state encoding.
package gpr_mport_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } gpr_state_e;

endpackage

// File: rtl/gpr_mport_wr_arb.sv
// Write-port arbiter: per-address merge, highest port index wins.
// Ports: wr_en/wr_adr in; win_en (one winner per address), conflict out.
module gpr_mport_wr_arb #(
  parameter int ADDR_W  = 5,
  parameter int NUM_WR  = 2,
  parameter int R0_ZERO = 1
) (
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_adr,
  output logic [NUM_WR-1:0]        win_en,
  output logic                     conflict
);

  logic [NUM_WR-1:0] live;

  // Writes to r0 are discarded before arbitration so they never
  // collide with anything.
  always_comb begin
    live     = '0;
    win_en   = '0;
    conflict = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      live[i] = wr_en[i];
      if (R0_ZERO != 0 &&
          wr_adr[i*ADDR_W +: ADDR_W] == '0)
        live[i] = 1'b0;
    end
    for (int i = 0; i < NUM_WR; i++) begin
      win_en[i] = live[i];
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (live[i] && live[j] &&
            wr_adr[i*ADDR_W +: ADDR_W] ==
            wr_adr[j*ADDR_W +: ADDR_W]) begin
          win_en[i] = 1'b0;
          conflict  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gpr_mport.sv
// Parametrised multi-port GPR file with bypass, hard r0, clear sequencer.
// Ports: clk, reset, power pins, rd_adr/rd_dat, wr_en/adr/dat, ready, wr_conflict.
module gpr_mport
  import gpr_mport_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 3,
  parameter int NUM_WR   = 2,
  parameter int R0_ZERO  = 1,
  parameter int RD_REG   = 0,
  parameter int BYPASS   = 1,
  parameter int INIT_CLR = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  inout  wire                      vccd1,
  inout  wire                      vssd1,
  input  logic [NUM_RD*ADDR_W-1:0] rd_adr,
  output logic [NUM_RD*DATA_W-1:0] rd_dat,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_adr,
  input  logic [NUM_WR*DATA_W-1:0] wr_dat,
  output logic                     ready,
  output logic                     wr_conflict
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  logic unused_pwr;
  assign unused_pwr = vccd1 ^ vssd1;

  gpr_state_e        state;
  gpr_state_e        state_nxt;
  logic [ADDR_W-1:0] clr_idx;
  logic              clr_we;
  logic              run;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [NUM_WR-1:0] win_en;
  logic [NUM_WR-1:0] we;
  logic              conflict;

  logic [NUM_RD*DATA_W-1:0] rd_nxt;

  assign run   = (state == ST_RUN);
  assign ready = run;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_nxt;
      if (clr_we)
        clr_idx <= clr_idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_we    = 1'b0;
    unique case (state)
      ST_CLEAR: begin
        if (INIT_CLR != 0) begin
          clr_we = 1'b1;
          if (clr_idx == LAST)
            state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: state_nxt = ST_RUN;
      default: state_nxt = ST_CLEAR;
    endcase
  end

  gpr_mport_wr_arb #(
    .ADDR_W  (ADDR_W),
    .NUM_WR  (NUM_WR),
    .R0_ZERO (R0_ZERO)
  ) u_arb (
    .wr_en    (wr_en),
    .wr_adr   (wr_adr),
    .win_en   (win_en),
    .conflict (conflict)
  );

  // Writes are only honoured once the clear sequence has finished.
  assign we = run ? win_en : '0;

  // Winners are unique per address, so loop order is irrelevant.
  always_ff @(posedge clk) begin
    if (clr_we)
      mem[clr_idx] <= '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (we[i])
        mem[wr_adr[i*ADDR_W +: ADDR_W]] <=
          wr_dat[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      wr_conflict <= 1'b0;
    else
      wr_conflict <= run & conflict;
  end

  // With bypass on, this is the post-write view of the entry, which
  // is also exactly what the registered read path must capture.
  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;
    rd_nxt = '0;
    a      = '0;
    v      = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      a = rd_adr[p*ADDR_W +: ADDR_W];
      v = mem[a];
      if (BYPASS != 0) begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (we[i] &&
              wr_adr[i*ADDR_W +: ADDR_W] == a)
            v = wr_dat[i*DATA_W +: DATA_W];
        end
      end
      if (R0_ZERO != 0 && a == '0)
        v = '0;
      if (!run)
        v = '0;
      rd_nxt[p*DATA_W +: DATA_W] = v;
    end
  end

  generate
    if (RD_REG != 0) begin : g_rd_reg
      logic [NUM_RD*DATA_W-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (reset)
          rd_q <= '0;
        else
          rd_q <= rd_nxt;
      end
      assign rd_dat = rd_q;
    end else begin : g_rd_comb
      assign rd_dat = rd_nxt;
    end
  endgenerate

endmodule

// File: tb/tb_gpr_mport.sv
// Bench for gpr_mport: default, no-bypass and registered-read builds.
// All three share stimulus; expected read data flows through a queue.
module tb_gpr_mport;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int NW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  wire  vccd1 = 1'b1;
  wire  vssd1 = 1'b0;

  logic [NR*AW-1:0] rd_adr;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_adr;
  logic [NW*DW-1:0] wr_dat;

  logic [NR*DW-1:0] rd_a, rd_b, rd_c;
  logic rdy_a, rdy_b, rdy_c;
  logic cf_a, cf_b, cf_c;

  int n_chk  = 0;
  int n_pass = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] e;

  gpr_mport dut_a (
    .clk(clk), .reset(reset),
    .vccd1(vccd1), .vssd1(vssd1),
    .rd_adr(rd_adr), .rd_dat(rd_a),
    .wr_en(wr_en), .wr_adr(wr_adr),
    .wr_dat(wr_dat), .ready(rdy_a),
    .wr_conflict(cf_a)
  );

  gpr_mport #(.BYPASS(0)) dut_b (
    .clk(clk), .reset(reset),
    .vccd1(vccd1), .vssd1(vssd1),
    .rd_adr(rd_adr), .rd_dat(rd_b),
    .wr_en(wr_en), .wr_adr(wr_adr),
    .wr_dat(wr_dat), .ready(rdy_b),
    .wr_conflict(cf_b)
  );

  gpr_mport #(.RD_REG(1)) dut_c (
    .clk(clk), .reset(reset),
    .vccd1(vccd1), .vssd1(vssd1),
    .rd_adr(rd_adr), .rd_dat(rd_c),
    .wr_en(wr_en), .wr_adr(wr_adr),
    .wr_dat(wr_dat), .ready(rdy_c),
    .wr_conflict(cf_c)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p,
                        input logic [AW-1:0] a);
    rd_adr[p*AW +: AW] = a;
  endtask

  task automatic set_wr(input int i,
                        input logic en,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    wr_en[i]           = en;
    wr_adr[i*AW +: AW] = a;
    wr_dat[i*DW +: DW] = d;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (n < 64) begin
      step();
      n++;
      if (rdy_a) break;
      n_chk++;
      if (rd_a[0 +: DW] !== '0 || cf_a !== 1'b0)
        $display("FAIL %s_clr_quiet rd %h cf %b req 0",
                 nm, rd_a[0 +: DW], cf_a);
      else
        n_pass++;
    end
    n_chk++;
    if (n !== 32)
      $display("FAIL %s_ready_cycle got %0d req 32",
               nm, n);
    else
      n_pass++;
    n_chk++;
    if ({rdy_b, rdy_c} !== 2'b11)
      $display("FAIL %s_ready_bc got %b req 11",
               nm, {rdy_b, rdy_c});
    else
      n_pass++;
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    rd_adr = '0;
    wr_en  = '0;
    wr_adr = '0;
    wr_dat = '0;
    step();
    step();
    n_chk++;
    if ({rdy_a, rdy_b, rdy_c, cf_a, cf_b, cf_c}
        !== 6'b0)
      $display("FAIL reset_flags got %b req 0",
               {rdy_a, rdy_b, rdy_c,
                cf_a, cf_b, cf_c});
    else
      n_pass++;
    n_chk++;
    if (rd_c !== '0)
      $display("FAIL reset_rdreg got %h req 0", rd_c);
    else
      n_pass++;
    reset = 1'b0;
    wait_ready("init");
  endtask

  task automatic test_cleared;
    for (int a = 0; a < 32; a++) begin
      for (int p = 0; p < NR; p++) begin
        set_rd(p, AW'(a));
        exp_q.push_back('0);
        exp_q.push_back('0);
      end
      #1;
      for (int p = 0; p < NR; p++) begin
        e = exp_q.pop_front();
        n_chk++;
        if (rd_a[p*DW +: DW] !== e)
          $display("FAIL clr_a adr %0d p%0d got %h req %h",
                   a, p, rd_a[p*DW +: DW], e);
        else
          n_pass++;
        e = exp_q.pop_front();
        n_chk++;
        if (rd_b[p*DW +: DW] !== e)
          $display("FAIL clr_b adr %0d p%0d got %h req %h",
                   a, p, rd_b[p*DW +: DW], e);
        else
          n_pass++;
      end
    end
    step();
  endtask

  task automatic test_bypass;
    set_wr(0, 1'b1, 5, 32'hDEADBEEF);
    set_rd(0, 5);
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front();
    n_chk++;
    if (rd_a[0 +: DW] !== e)
      $display("FAIL byp_same got %h req %h",
               rd_a[0 +: DW], e);
    else
      n_pass++;
    e = exp_q.pop_front();
    n_chk++;
    if (rd_b[0 +: DW] !== e)
      $display("FAIL nobyp_same got %h req %h",
               rd_b[0 +: DW], e);
    else
      n_pass++;
    step();
    wr_en = '0;
    repeat (3) exp_q.push_back(32'hDEADBEEF);
    #1;
    e = exp_q.pop_front();
    n_chk++;
    if (rd_a[0 +: DW] !== e)
      $display("FAIL byp_next got %h req %h",
               rd_a[0 +: DW], e);
    else
      n_pass++;
    e = exp_q.pop_front();
    n_chk++;
    if (rd_b[0 +: DW] !== e)
      $display("FAIL nobyp_next got %h req %h",
               rd_b[0 +: DW], e);
    else
      n_pass++;
    e = exp_q.pop_front();
    n_chk++;
    if (rd_c[0 +: DW] !== e)
      $display("FAIL rdreg_byp got %h req %h",
               rd_c[0 +: DW], e);
    else
      n_pass++;
    step();
  endtask

  task automatic test_conflict;
    set_wr(0, 1'b1, 7, 32'h1111);
    set_wr(1, 1'b1, 7, 32'h2222);
    set_rd(1, 7);
    exp_q.push_back(32'h2222);
    #1;
    e = exp_q.pop_front();
    n_chk++;
    if (rd_a[DW +: DW] !== e)
      $display("FAIL cfl_byp got %h req %h",
               rd_a[DW +: DW], e);
    else
      n_pass++;
    n_chk++;
    if (cf_a !== 1'b0)
      $display("FAIL cfl_early got %b req 0", cf_a);
    else
      n_pass++;
    step();
    wr_en = '0;
    exp_q.push_back(32'h2222);
    exp_q.push_back(32'h2222);
    #1;
    n_chk++;
    if ({cf_a, cf_b, cf_c} !== 3'b111)
      $display("FAIL cfl_flag got %b req 111",
               {cf_a, cf_b, cf_c});
    else
      n_pass++;
    e = exp_q.pop_front();
    n_chk++;
    if (rd_a[DW +: DW] !== e)
      $display("FAIL cfl_win_a got %h req %h",
               rd_a[DW +: DW], e);
    else
      n_pass++;
    e = exp_q.pop_front();
    n_chk++;
    if (rd_b[DW +: DW] !== e)
      $display("FAIL cfl_win_b got %h req %h",
               rd_b[DW +: DW], e);
    else
      n_pass++;
    step();
    n_chk++;
    if ({cf_a, cf_b, cf_c} !== 3'b000)
      $display("FAIL cfl_clear got %b req 000",
               {cf_a, cf_b, cf_c});
    else
      n_pass++;
  endtask

  task automatic test_r0;
    set_wr(0, 1'b1, 0, 32'hFFFFFFFF);
    set_wr(1, 1'b1, 0, 32'hFFFFFFFF);
    for (int p = 0; p < NR; p++) begin
      set_rd(p, 0);
      exp_q.push_back('0);
    end
    #1;
    for (int p = 0; p < NR; p++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (rd_a[p*DW +: DW] !== e)
        $display("FAIL r0_byp p%0d got %h req %h",
                 p, rd_a[p*DW +: DW], e);
      else
        n_pass++;
    end
    step();
    wr_en = '0;
    for (int p = 0; p < NR; p++) begin
      exp_q.push_back('0);
      exp_q.push_back('0);
    end
    #1;
    n_chk++;
    if ({cf_a, cf_b, cf_c} !== 3'b000)
      $display("FAIL r0_cfl got %b req 000",
               {cf_a, cf_b, cf_c});
    else
      n_pass++;
    for (int p = 0; p < NR; p++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (rd_b[p*DW +: DW] !== e)
        $display("FAIL r0_rd p%0d got %h req %h",
                 p, rd_b[p*DW +: DW], e);
      else
        n_pass++;
      e = exp_q.pop_front();
      n_chk++;
      if (rd_c[p*DW +: DW] !== e)
        $display("FAIL r0_rdreg p%0d got %h req %h",
                 p, rd_c[p*DW +: DW], e);
      else
        n_pass++;
    end
  endtask

  task automatic test_rd_reg;
    set_wr(0, 1'b1, 3, 32'hA5A5A5A5);
    set_rd(1, 9);
    step();
    wr_en = '0;
    set_rd(1, 3);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hA5A5A5A5);
    exp_q.push_back(32'hA5A5A5A5);
    #1;
    e = exp_q.pop_front();
    n_chk++;
    if (rd_c[DW +: DW] !== e)
      $display("FAIL rdreg_lag got %h req %h",
               rd_c[DW +: DW], e);
    else
      n_pass++;
    e = exp_q.pop_front();
    n_chk++;
    if (rd_a[DW +: DW] !== e)
      $display("FAIL rdcomb_now got %h req %h",
               rd_a[DW +: DW], e);
    else
      n_pass++;
    step();
    e = exp_q.pop_front();
    n_chk++;
    if (rd_c[DW +: DW] !== e)
      $display("FAIL rdreg_val got %h req %h",
               rd_c[DW +: DW], e);
    else
      n_pass++;
  endtask

  task automatic test_mid_clear_reset;
    set_wr(0, 1'b1, 4, 32'h1234);
    step();
    wr_en = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_wr(0, 1'b1, 4, 32'h55);
    set_rd(0, 4);
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_ready("mid");
    wr_en = '0;
    for (int p = 0; p < NR; p++) begin
      set_rd(p, 4);
      exp_q.push_back('0);
      exp_q.push_back('0);
    end
    #1;
    for (int p = 0; p < NR; p++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (rd_a[p*DW +: DW] !== e)
        $display("FAIL lost_wr_a p%0d got %h req %h",
                 p, rd_a[p*DW +: DW], e);
      else
        n_pass++;
      e = exp_q.pop_front();
      n_chk++;
      if (rd_b[p*DW +: DW] !== e)
        $display("FAIL lost_wr_b p%0d got %h req %h",
                 p, rd_b[p*DW +: DW], e);
      else
        n_pass++;
    end
    step();
    exp_q.push_back('0);
    e = exp_q.pop_front();
    n_chk++;
    if (rd_c[0 +: DW] !== e)
      $display("FAIL lost_wr_c got %h req %h",
               rd_c[0 +: DW], e);
    else
      n_pass++;
  endtask

  initial begin
    test_reset();
    test_cleared();
    test_bypass();
    test_conflict();
    test_r0();
    test_rd_reg();
    test_mid_clear_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
